pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: resolves jump flushes, EX busy stalls and load-use
// hazards, carries the wb/mem control sideband from ID into EX and MEM, and
// keeps saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int unsigned CTRL_W       = 2,
  parameter int unsigned RA_W         = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              ex2cu_jump_en_i,
  input  logic              ex2cu_busy_i,
  input  logic              ex2cu_load_i,
  input  logic [RA_W-1:0]   ex2cu_rd_i,
  input  logic [RA_W-1:0]   id2cu_rs1_i,
  input  logic [RA_W-1:0]   id2cu_rs2_i,
  input  logic              id2cu_rs1_en_i,
  input  logic              id2cu_rs2_en_i,
  input  logic [CTRL_W-1:0] id2cu_ctrl_i,
  output logic              cu2_refresh_flag_o,
  output logic              cu2pc_jump_en_o,
  output logic              cu2pc_stall_o,
  output logic              cu2ifid_stall_o,
  output logic [CTRL_W-1:0] cu2ex_ctrl_o,
  output logic [CTRL_W-1:0] cu2mem_ctrl_o,
  output logic [CNT_W-1:0]  cu_stall_cnt_o,
  output logic [CNT_W-1:0]  cu_flush_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  // Remaining flush cycles loaded on an accepted jump (the jump cycle itself
  // already counts as the first refresh cycle).
  localparam logic [3:0] FC_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam bit         FC_MULTI = (FLUSH_CYCLES > 1);

  state_t     state, state_n;
  logic [3:0] fc, fc_n;

  logic jmp;
  logic rs1_hit, rs2_hit;
  logic lu;
  logic stall;
  logic flushing;

  // Hazard detection: busy masks the jump; load-use only checked while running.
  always_comb begin
    jmp      = ex2cu_jump_en_i & ~ex2cu_busy_i;
    rs1_hit  = id2cu_rs1_en_i & (id2cu_rs1_i == ex2cu_rd_i);
    rs2_hit  = id2cu_rs2_en_i & (id2cu_rs2_i == ex2cu_rd_i);
    lu       = ex2cu_load_i & (ex2cu_rd_i != '0) & (rs1_hit | rs2_hit)
               & ~jmp & ~ex2cu_busy_i & (state == S_RUN);
    stall    = (ex2cu_busy_i & ~jmp) | lu;
    flushing = jmp | (state == S_FLUSH);
  end

  // Externally visible strobes, forced low while reset is held.
  always_comb begin
    cu2pc_jump_en_o    = rest & jmp;
    cu2_refresh_flag_o = rest & flushing;
    cu2pc_stall_o      = rest & stall;
    cu2ifid_stall_o    = rest & stall;
  end

  // Next-state logic: a jump from any state (re)starts the flush window.
  always_comb begin
    state_n = state;
    fc_n    = fc;
    if (jmp) begin
      if (FC_MULTI) begin
        state_n = S_FLUSH;
        fc_n    = FC_INIT;
      end else begin
        state_n = S_RUN;
        fc_n    = '0;
      end
    end else begin
      unique case (state)
        S_RUN: begin
          if (ex2cu_busy_i) state_n = S_BUSY;
        end
        S_FLUSH: begin
          fc_n = fc - 4'd1;
          if (fc == 4'd1) state_n = S_RUN;
        end
        S_BUSY: begin
          if (!ex2cu_busy_i) state_n = S_RUN;
        end
        default: begin
          state_n = S_RUN;
          fc_n    = '0;
        end
      endcase
    end
  end

  // FSM state and flush remainder registers.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= S_RUN;
      fc    <= '0;
    end else begin
      state <= state_n;
      fc    <= fc_n;
    end
  end

  // Control sideband pipe: flush beats busy beats load-use beats normal flow.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      cu2ex_ctrl_o  <= '0;
      cu2mem_ctrl_o <= '0;
    end else if (flushing) begin
      cu2ex_ctrl_o  <= '0;
      cu2mem_ctrl_o <= cu2ex_ctrl_o;
    end else if (ex2cu_busy_i) begin
      cu2ex_ctrl_o  <= cu2ex_ctrl_o;
      cu2mem_ctrl_o <= '0;
    end else if (lu) begin
      cu2ex_ctrl_o  <= '0;
      cu2mem_ctrl_o <= cu2ex_ctrl_o;
    end else begin
      cu2ex_ctrl_o  <= id2cu_ctrl_i;
      cu2mem_ctrl_o <= cu2ex_ctrl_o;
    end
  end

  // Saturating performance counters for stall cycles and accepted jumps.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      cu_stall_cnt_o <= '0;
      cu_flush_cnt_o <= '0;
    end else begin
      if (stall && (cu_stall_cnt_o != '1))
        cu_stall_cnt_o <= cu_stall_cnt_o + CNT_W'(1);
      if (jmp && (cu_flush_cnt_o != '1))
        cu_flush_cnt_o <= cu_flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Main instance uses FLUSH_CYCLES=3 and
// CNT_W=4; a second instance with FLUSH_CYCLES=1, CNT_W=16 shares the inputs.
module tb_pipe_ctrl;

  logic       clk;
  logic       rest;
  logic       jump_en, busy, load;
  logic [4:0] rd, rs1, rs2;
  logic       rs1_en, rs2_en;
  logic [1:0] ctrl;

  logic       refresh, jump_o, pstall, istall;
  logic [1:0] ex_ctrl, mem_ctrl;
  logic [3:0] scnt, fcnt;

  logic        d1_refresh, d1_jump, d1_pstall, d1_istall;
  logic [1:0]  d1_ex, d1_mem;
  logic [15:0] d1_scnt, d1_fcnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.CTRL_W(2), .RA_W(5), .FLUSH_CYCLES(3), .CNT_W(4)) u_dut (
    .clk(clk), .rest(rest),
    .ex2cu_jump_en_i(jump_en), .ex2cu_busy_i(busy), .ex2cu_load_i(load),
    .ex2cu_rd_i(rd), .id2cu_rs1_i(rs1), .id2cu_rs2_i(rs2),
    .id2cu_rs1_en_i(rs1_en), .id2cu_rs2_en_i(rs2_en), .id2cu_ctrl_i(ctrl),
    .cu2_refresh_flag_o(refresh), .cu2pc_jump_en_o(jump_o),
    .cu2pc_stall_o(pstall), .cu2ifid_stall_o(istall),
    .cu2ex_ctrl_o(ex_ctrl), .cu2mem_ctrl_o(mem_ctrl),
    .cu_stall_cnt_o(scnt), .cu_flush_cnt_o(fcnt)
  );

  pipe_ctrl #(.CTRL_W(2), .RA_W(5), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rest(rest),
    .ex2cu_jump_en_i(jump_en), .ex2cu_busy_i(busy), .ex2cu_load_i(load),
    .ex2cu_rd_i(rd), .id2cu_rs1_i(rs1), .id2cu_rs2_i(rs2),
    .id2cu_rs1_en_i(rs1_en), .id2cu_rs2_en_i(rs2_en), .id2cu_ctrl_i(ctrl),
    .cu2_refresh_flag_o(d1_refresh), .cu2pc_jump_en_o(d1_jump),
    .cu2pc_stall_o(d1_pstall), .cu2ifid_stall_o(d1_istall),
    .cu2ex_ctrl_o(d1_ex), .cu2mem_ctrl_o(d1_mem),
    .cu_stall_cnt_o(d1_scnt), .cu_flush_cnt_o(d1_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; registered outputs are stable after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    jump_en = 0; busy = 0; load = 0;
    rd = 0; rs1 = 0; rs2 = 0; rs1_en = 0; rs2_en = 0; ctrl = 0;
  endtask

  task automatic do_reset();
    idle();
    rest = 0;
    tick();
    rest = 1;
  endtask

  task automatic test_reset();
    idle();
    rest = 0;
    tick();
    rest = 1;
    ctrl = 2'b11; tick();
    ctrl = 2'b10; tick();
    jump_en = 1; busy = 0;
    #1;
    if (jump_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_jump: got %b exp 1", jump_o); end n_tests++;
    rest = 0;
    #1;
    if (jump_o !== 1'b0) begin n_fail++; $display("FAIL rst_jump: got %b exp 0", jump_o); end n_tests++;
    if (refresh !== 1'b0) begin n_fail++; $display("FAIL rst_refresh: got %b exp 0", refresh); end n_tests++;
    if ({pstall, istall} !== 2'b00) begin n_fail++; $display("FAIL rst_stall: got %b exp 00", {pstall, istall}); end n_tests++;
    if (ex_ctrl !== 2'b00) begin n_fail++; $display("FAIL rst_ex: got %b exp 00", ex_ctrl); end n_tests++;
    if (mem_ctrl !== 2'b00) begin n_fail++; $display("FAIL rst_mem: got %b exp 00", mem_ctrl); end n_tests++;
    if ({scnt, fcnt} !== 8'h00) begin n_fail++; $display("FAIL rst_cnt: got %h exp 00", {scnt, fcnt}); end n_tests++;
    idle();
    tick();
    rest = 1;
  endtask

  task automatic test_pass_through();
    do_reset();
    ctrl = 2'b01;
    #1;
    if ({pstall, istall, refresh} !== 3'b000) begin n_fail++; $display("FAIL pt_quiet: got %b exp 000", {pstall, istall, refresh}); end n_tests++;
    tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b0100) begin n_fail++; $display("FAIL pt_c1: got %b exp 0100", {ex_ctrl, mem_ctrl}); end n_tests++;
    ctrl = 2'b10; tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b1001) begin n_fail++; $display("FAIL pt_c2: got %b exp 1001", {ex_ctrl, mem_ctrl}); end n_tests++;
    ctrl = 2'b11; tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b1110) begin n_fail++; $display("FAIL pt_c3: got %b exp 1110", {ex_ctrl, mem_ctrl}); end n_tests++;
    ctrl = 2'b00; tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b0011) begin n_fail++; $display("FAIL pt_c4: got %b exp 0011", {ex_ctrl, mem_ctrl}); end n_tests++;
    if ({scnt, fcnt} !== 8'h00) begin n_fail++; $display("FAIL pt_cnt: got %h exp 00", {scnt, fcnt}); end n_tests++;
  endtask

  task automatic test_load_use();
    do_reset();
    ctrl = 2'b11; tick();
    load = 1; rd = 5'd5; rs2 = 5'd5; rs2_en = 1; ctrl = 2'b10;
    #1;
    if ({pstall, istall} !== 2'b11) begin n_fail++; $display("FAIL lu_stall: got %b exp 11", {pstall, istall}); end n_tests++;
    tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b0011) begin n_fail++; $display("FAIL lu_bubble: got %b exp 0011", {ex_ctrl, mem_ctrl}); end n_tests++;
    if (scnt !== 4'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d exp 1", scnt); end n_tests++;
    load = 0;
    #1;
    if ({pstall, istall} !== 2'b00) begin n_fail++; $display("FAIL lu_one_cycle: got %b exp 00", {pstall, istall}); end n_tests++;
    tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b1000) begin n_fail++; $display("FAIL lu_resume: got %b exp 1000", {ex_ctrl, mem_ctrl}); end n_tests++;
    if (scnt !== 4'd1) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d exp 1", scnt); end n_tests++;
    // rd = 0 never hazards
    load = 1; rd = 5'd0; rs1 = 5'd0; rs1_en = 1; rs2 = 5'd0; rs2_en = 1; ctrl = 2'b01;
    #1;
    if (pstall !== 1'b0) begin n_fail++; $display("FAIL lu_rd0: got %b exp 0", pstall); end n_tests++;
    tick();
    if (ex_ctrl !== 2'b01) begin n_fail++; $display("FAIL lu_rd0_ex: got %b exp 01", ex_ctrl); end n_tests++;
    // matching register that is not actually read
    rd = 5'd7; rs1 = 5'd7; rs1_en = 0; rs2 = 5'd3; rs2_en = 1;
    #1;
    if (pstall !== 1'b0) begin n_fail++; $display("FAIL lu_noen: got %b exp 0", pstall); end n_tests++;
    // rs1 path hazard
    rs1_en = 1;
    #1;
    if (pstall !== 1'b1) begin n_fail++; $display("FAIL lu_rs1: got %b exp 1", pstall); end n_tests++;
    idle();
  endtask

  task automatic test_jump();
    do_reset();
    ctrl = 2'b01; tick();
    jump_en = 1; ctrl = 2'b10;
    #1;
    if ({jump_o, refresh, d1_refresh} !== 3'b111) begin n_fail++; $display("FAIL jmp_c1: got %b exp 111", {jump_o, refresh, d1_refresh}); end n_tests++;
    tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b0001) begin n_fail++; $display("FAIL jmp_e1: got %b exp 0001", {ex_ctrl, mem_ctrl}); end n_tests++;
    if (fcnt !== 4'd1) begin n_fail++; $display("FAIL jmp_cnt: got %0d exp 1", fcnt); end n_tests++;
    jump_en = 0;
    #1;
    if ({jump_o, refresh, d1_refresh} !== 3'b010) begin n_fail++; $display("FAIL jmp_c2: got %b exp 010", {jump_o, refresh, d1_refresh}); end n_tests++;
    tick();
    if (ex_ctrl !== 2'b00) begin n_fail++; $display("FAIL jmp_e2: got %b exp 00", ex_ctrl); end n_tests++;
    if (d1_ex !== 2'b10) begin n_fail++; $display("FAIL jmp_f1_ex: got %b exp 10", d1_ex); end n_tests++;
    if (refresh !== 1'b1) begin n_fail++; $display("FAIL jmp_c3: got %b exp 1", refresh); end n_tests++;
    tick();
    if (ex_ctrl !== 2'b00) begin n_fail++; $display("FAIL jmp_e3: got %b exp 00", ex_ctrl); end n_tests++;
    if (refresh !== 1'b0) begin n_fail++; $display("FAIL jmp_end: got %b exp 0", refresh); end n_tests++;
    tick();
    if (ex_ctrl !== 2'b10) begin n_fail++; $display("FAIL jmp_resume: got %b exp 10", ex_ctrl); end n_tests++;
    if ({fcnt, d1_fcnt} !== {4'd1, 16'd1}) begin n_fail++; $display("FAIL jmp_cnt_final: got %h exp 10001", {fcnt, d1_fcnt}); end n_tests++;
  endtask

  task automatic test_jump_restart();
    do_reset();
    jump_en = 1; tick();
    jump_en = 0; tick();
    jump_en = 1;
    #1;
    if ({jump_o, refresh} !== 2'b11) begin n_fail++; $display("FAIL rj_jump: got %b exp 11", {jump_o, refresh}); end n_tests++;
    tick();
    jump_en = 0;
    #1;
    if (refresh !== 1'b1) begin n_fail++; $display("FAIL rj_r1: got %b exp 1", refresh); end n_tests++;
    tick();
    if (refresh !== 1'b1) begin n_fail++; $display("FAIL rj_r2: got %b exp 1", refresh); end n_tests++;
    tick();
    if (refresh !== 1'b0) begin n_fail++; $display("FAIL rj_end: got %b exp 0", refresh); end n_tests++;
    if (fcnt !== 4'd2) begin n_fail++; $display("FAIL rj_cnt: got %0d exp 2", fcnt); end n_tests++;
  endtask

  task automatic test_busy_jump();
    do_reset();
    ctrl = 2'b01; tick();
    ctrl = 2'b10; tick();
    busy = 1; jump_en = 1; ctrl = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      if ({pstall, istall, jump_o} !== 3'b110) begin n_fail++; $display("FAIL bj_stall%0d: got %b exp 110", i, {pstall, istall, jump_o}); end n_tests++;
      tick();
      if ({ex_ctrl, mem_ctrl} !== 4'b1000) begin n_fail++; $display("FAIL bj_hold%0d: got %b exp 1000", i, {ex_ctrl, mem_ctrl}); end n_tests++;
    end
    busy = 0;
    #1;
    if ({jump_o, refresh, pstall} !== 3'b110) begin n_fail++; $display("FAIL bj_c5: got %b exp 110", {jump_o, refresh, pstall}); end n_tests++;
    tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b0010) begin n_fail++; $display("FAIL bj_flush: got %b exp 0010", {ex_ctrl, mem_ctrl}); end n_tests++;
    if ({scnt, fcnt} !== {4'd4, 4'd1}) begin n_fail++; $display("FAIL bj_cnt: got %h exp 41", {scnt, fcnt}); end n_tests++;
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    ctrl = 2'b11; tick();
    busy = 1;
    for (int i = 0; i < 15; i++) tick();
    if (scnt !== 4'd15) begin n_fail++; $display("FAIL sat_15: got %0d exp 15", scnt); end n_tests++;
    for (int i = 0; i < 5; i++) tick();
    if (scnt !== 4'd15) begin n_fail++; $display("FAIL sat_20: got %0d exp 15", scnt); end n_tests++;
    if (d1_scnt !== 16'd20) begin n_fail++; $display("FAIL sat_wide: got %0d exp 20", d1_scnt); end n_tests++;
    if ({ex_ctrl, mem_ctrl} !== 4'b1100) begin n_fail++; $display("FAIL sat_hold: got %b exp 1100", {ex_ctrl, mem_ctrl}); end n_tests++;
    jump_en = 1;
    rest = 0;
    #1;
    if ({jump_o, refresh, pstall, istall} !== 4'b0000) begin n_fail++; $display("FAIL sat_rst_comb: got %b exp 0000", {jump_o, refresh, pstall, istall}); end n_tests++;
    if ({ex_ctrl, mem_ctrl, scnt, fcnt} !== 12'h000) begin n_fail++; $display("FAIL sat_rst_regs: got %h exp 000", {ex_ctrl, mem_ctrl, scnt, fcnt}); end n_tests++;
    idle();
    tick();
    // first cycle after release must behave as running (load-use is live)
    load = 1; rd = 5'd4; rs1 = 5'd4; rs1_en = 1; ctrl = 2'b01;
    rest = 1;
    #1;
    if (pstall !== 1'b1) begin n_fail++; $display("FAIL sat_post_run: got %b exp 1", pstall); end n_tests++;
    tick();
    if ({ex_ctrl, scnt} !== {2'b00, 4'd1}) begin n_fail++; $display("FAIL sat_post_lu: got %h exp 01", {ex_ctrl, scnt}); end n_tests++;
    load = 0; tick();
    if (ex_ctrl !== 2'b01) begin n_fail++; $display("FAIL sat_pt1: got %b exp 01", ex_ctrl); end n_tests++;
    ctrl = 2'b10; tick();
    if ({ex_ctrl, mem_ctrl} !== 4'b1001) begin n_fail++; $display("FAIL sat_pt2: got %b exp 1001", {ex_ctrl, mem_ctrl}); end n_tests++;
    idle();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_jump();
    test_jump_restart();
    test_busy_jump();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
